key_entry_assembler: RTL
========================

// Module: key_entry_assembler
// PURPOSE
//  Upstream stage of the access controller. Collects two decimal digits from the keypad
//  scanner over a valid/ready handshake and encodes them as two excess-3 nibbles.
//  Drives the 8-bit key for a fixed hold window when ENTER is pressed.
//  Key is 0 whenever no entry is being presented. A presented key is never 0, since
//  each excess-3 nibble is in the range 3..12.
// PARAMETERS
//  TIMEOUT_CYCLES  1000  max idle cycles between accepted inputs before entry is discarded (>=2)
//  HOLD_CYCLES     4     cycles key/key_valid are held for the downstream controller (>=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  digit_valid  in   1   scanner has a digit on `digit`
//  digit        in   4   BCD digit, legal values 0..9
//  digit_ready  out  1   block can accept a digit (decoded from state)
//  enter        in   1   ENTER key, one-cycle pulse
//  clear        in   1   CLEAR key, one-cycle pulse
//  key          out  8   {excess3(first), excess3(second)}; 0 when not presenting
//  key_valid    out  1   high while key is presented
//  entry_count  out  2   digits currently held (0..2)
//  digit_err    out  1   one-cycle pulse: illegal digit, or premature enter
//  timeout      out  1   one-cycle pulse: entry discarded by timeout
// BEHAVIOUR
//  - Reset (async): state=IDLE; key=0, key_valid=0, entry_count=0, digit_err=0,
//    timeout=0, timer=0. digit_ready=1 while in reset.
//  - All outputs except digit_ready are registered.
//  - States and digit_ready:
//      IDLE(0 digits, ready=1)   ONE(1 digit, ready=1)
//      TWO(2 digits, ready=0)    PRESENT(ready=0)
//  - Accept: digit_valid & digit_ready & digit<=9.
//      IDLE->ONE stores hi = digit+3.
//      ONE->TWO stores lo = digit+3.
//      Each accept sets timer=0.
//  - Illegal digit (digit_valid & digit_ready & digit>9): pulse digit_err next cycle;
//    state and stored digits are unchanged; timer is not reset.
//  - digit_valid in TWO or PRESENT: ignored, no error (handshake not completed).
//  - Enter in TWO: next cycle key={hi,lo}, key_valid=1, state=PRESENT. Latency 1 cycle.
//  - Enter in IDLE or ONE with no digit accepted that cycle: pulse digit_err; state->IDLE.
//  - Enter in ONE in the same cycle as an accepted digit: digit is accepted, enter is
//    ignored, no error.
//  - PRESENT: key and key_valid are held for exactly HOLD_CYCLES cycles. Then key=0,
//    key_valid=0, state->IDLE, stored digits cleared. enter, clear and digits are ignored.
//  - Clear in IDLE/ONE/TWO: state->IDLE next cycle, digits cleared.
//    Clear has priority over digit and enter in the same cycle.
//  - Timeout: timer counts every cycle in ONE/TWO. When it reaches TIMEOUT_CYCLES-1:
//    state->IDLE, pulse timeout. Clear or enter in that same cycle wins; no timeout pulse.
//  - timer is held at 0 in IDLE and PRESENT. Width is $clog2(TIMEOUT_CYCLES). Saturating
//    is not needed because of the wrap-back to IDLE.
//  - entry_count mirrors the state: IDLE=0, ONE=1, TWO=2, PRESENT=2.
//  - Reset asserted mid-PRESENT: key drops to 0 asynchronously and no partial hold
//    resumes after release.
// TESTING
//  - Reset then digits 4,7, enter -> one cycle later key=8'h7A, key_valid=1 for 4 cycles,
//    then key=0, entry_count=0.
//  - Digits 0,0, enter -> key=8'h33 (nonzero), held HOLD_CYCLES cycles.
//  - digit=4'hB offered in IDLE -> digit_err pulse, entry_count stays 0, digit_ready stays 1.
//  - Digit 5, then enter -> digit_err pulse, state IDLE, key stays 0.
//  - Digit 2, then TIMEOUT_CYCLES idle cycles -> timeout pulse, entry_count=0.
//    Clear and enter in the same cycle as timer expiry -> no timeout pulse.
//  - Digits 1,2, enter. During PRESENT apply clear, digit 9 and enter -> key=8'h45 is held
//    unchanged; rst pulse mid-hold -> key=0 immediately.

Source files
------------

// File: rtl/key_entry_assembler.sv
// Key entry assembler: collects two BCD digits over valid/ready, encodes each as
// excess-3, and presents the 8-bit key for a fixed hold window on ENTER.
module key_entry_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_digit_valid,
    input  logic [3:0] i_digit,
    output logic       o_digit_ready,
    input  logic       i_enter,
    input  logic       i_clear,
    output logic [7:0] o_key,
    output logic       o_key_valid,
    output logic [1:0] o_entry_count,
    output logic       o_digit_err,
    output logic       o_timeout
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StOne, StTwo, StPresent} state_e;

    state_e          r_state, w_state_d;
    logic [3:0]      r_hi, w_hi_d;
    logic [3:0]      r_lo, w_lo_d;
    logic [TW-1:0]   r_timer, w_timer_d;
    logic [HW-1:0]   r_hold, w_hold_d;
    logic [7:0]      r_key, w_key_d;
    logic            r_key_valid, w_key_valid_d;
    logic [1:0]      r_entry_count, w_entry_count_d;
    logic            r_digit_err, w_digit_err_d;
    logic            r_timeout, w_timeout_d;

    logic            w_ready;
    logic            w_accept;
    logic            w_illegal;
    logic            w_expired;

    assign w_ready   = (r_state == StIdle) || (r_state == StOne);
    assign w_accept  = i_digit_valid && w_ready && (i_digit <= 4'd9);
    assign w_illegal = i_digit_valid && w_ready && (i_digit > 4'd9);
    assign w_expired = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output decode; priority clear > enter > accept > timeout.
    always_comb begin
        w_state_d       = r_state;
        w_hi_d          = r_hi;
        w_lo_d          = r_lo;
        w_hold_d        = '0;
        w_digit_err_d   = 1'b0;
        w_timeout_d     = 1'b0;
        w_timer_d       = '0;
        w_key_d         = 8'h00;
        w_key_valid_d   = 1'b0;
        w_entry_count_d = 2'd0;

        if (r_state == StPresent) begin
            // Hold window ignores all keypad input.
            if (r_hold == HW'(HOLD_CYCLES - 1)) begin
                w_state_d = StIdle;
            end else begin
                w_hold_d = r_hold + HW'(1);
            end
        end else if (i_clear) begin
            w_state_d = StIdle;
        end else if (i_enter && (r_state == StTwo)) begin
            w_state_d = StPresent;
        end else if (w_accept) begin
            if (r_state == StIdle) begin
                w_state_d = StOne;
                w_hi_d    = i_digit + 4'd3;
            end else begin
                w_state_d = StTwo;
                w_lo_d    = i_digit + 4'd3;
            end
        end else if (i_enter) begin
            // Premature enter with fewer than two digits.
            w_digit_err_d = 1'b1;
            w_state_d     = StIdle;
        end else begin
            w_digit_err_d = w_illegal;
            if ((r_state != StIdle) && w_expired) begin
                w_state_d   = StIdle;
                w_timeout_d = 1'b1;
            end
        end

        if (w_state_d == StIdle) begin
            w_hi_d = 4'd0;
            w_lo_d = 4'd0;
        end

        // Timer runs only while digits are pending; any accept restarts it.
        if ((w_state_d == StOne) || (w_state_d == StTwo)) begin
            w_timer_d = w_accept ? '0 : r_timer + TW'(1);
        end

        if (w_state_d == StPresent) begin
            w_key_d       = {w_hi_d, w_lo_d};
            w_key_valid_d = 1'b1;
        end

        unique case (w_state_d)
            StIdle:    w_entry_count_d = 2'd0;
            StOne:     w_entry_count_d = 2'd1;
            StTwo:     w_entry_count_d = 2'd2;
            StPresent: w_entry_count_d = 2'd2;
            default:   w_entry_count_d = 2'd0;
        endcase
    end

    // State and registered outputs with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_hi          <= 4'd0;
            r_lo          <= 4'd0;
            r_timer       <= '0;
            r_hold        <= '0;
            r_key         <= 8'h00;
            r_key_valid   <= 1'b0;
            r_entry_count <= 2'd0;
            r_digit_err   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_hi          <= w_hi_d;
            r_lo          <= w_lo_d;
            r_timer       <= w_timer_d;
            r_hold        <= w_hold_d;
            r_key         <= w_key_d;
            r_key_valid   <= w_key_valid_d;
            r_entry_count <= w_entry_count_d;
            r_digit_err   <= w_digit_err_d;
            r_timeout     <= w_timeout_d;
        end
    end

    assign o_digit_ready = w_ready;
    assign o_key         = r_key;
    assign o_key_valid   = r_key_valid;
    assign o_entry_count = r_entry_count;
    assign o_digit_err   = r_digit_err;
    assign o_timeout     = r_timeout;

endmodule
